// File: rtl/hdu_sb_if.sv
// -----------------------------------------------------------------------------
// hdu_sb_if : decode <-> hazard scoreboard bundle.
//
// Carries the two issue-slot descriptors, the retirement ports, the flush
// strobe and the grant/ID/lock results of hdu_sb.
//   master : decode / retire side (drives slot + commit + flush, reads grants)
//   slave  : hdu_sb itself
// Parameters: REG_W register address width, ID_W commit ID width,
//             COMMIT_PORTS number of retirement ports.
// -----------------------------------------------------------------------------
interface hdu_sb_if #(
    parameter int REG_W        = 5,
    parameter int ID_W         = 3,
    parameter int COMMIT_PORTS = 2
);
    logic                         a_valid_i;
    logic [REG_W-1:0]             a_rd_i;
    logic [REG_W-1:0]             a_rs1_i;
    logic [REG_W-1:0]             a_rs2_i;
    logic                         a_rd_we_i;
    logic                         a_br_i;
    logic                         a_csr_i;

    logic                         b_valid_i;
    logic [REG_W-1:0]             b_rd_i;
    logic [REG_W-1:0]             b_rs1_i;
    logic [REG_W-1:0]             b_rs2_i;
    logic                         b_rd_we_i;
    logic                         b_csr_i;

    logic [COMMIT_PORTS-1:0]      commit_valid_i;
    logic [COMMIT_PORTS*ID_W-1:0] commit_id_i;
    logic                         flush_i;

    logic [1:0]                   issue_o;
    logic                         stall_o;
    logic [ID_W-1:0]              a_id_o;
    logic [ID_W-1:0]              b_id_o;
    logic                         lock_o;

    modport master (
        output a_valid_i, a_rd_i, a_rs1_i, a_rs2_i, a_rd_we_i, a_br_i, a_csr_i,
        output b_valid_i, b_rd_i, b_rs1_i, b_rs2_i, b_rd_we_i, b_csr_i,
        output commit_valid_i, commit_id_i, flush_i,
        input  issue_o, stall_o, a_id_o, b_id_o, lock_o
    );

    modport slave (
        input  a_valid_i, a_rd_i, a_rs1_i, a_rs2_i, a_rd_we_i, a_br_i, a_csr_i,
        input  b_valid_i, b_rd_i, b_rs1_i, b_rs2_i, b_rd_we_i, b_csr_i,
        input  commit_valid_i, commit_id_i, flush_i,
        output issue_o, stall_o, a_id_o, b_id_o, lock_o
    );
endinterface

// File: rtl/hdu_sb.sv
// -----------------------------------------------------------------------------
// hdu_sb : parametrised dual-issue hazard scoreboard.
//
// Tracks destination registers of in-flight long-latency instructions in a
// DEPTH-entry table and grants issue to slot A / slot B when no RAW, WAW,
// intra-pair or B-before-A WAR hazard exists and enough free entries remain.
// Granted slots receive commit IDs; COMMIT_PORTS retirements per cycle free
// entries, with same-cycle bypass for hazard checks (not for capacity).
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : hdu_sb_if.slave (slot descriptors, commits, flush, grants/IDs)
//   perf_raw_o / perf_waw_o / perf_full_o : 32-bit denial counters, present
//            only when HDU_PERF_CNT_EN is defined.
//
// Optional feature macro: HDU_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module hdu_sb #(
    parameter int DEPTH        = 8,
    parameter int ID_W         = $clog2(DEPTH),
    parameter int COMMIT_PORTS = 2,
    parameter int REG_W        = 5,
    parameter int BR_HOLD      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    hdu_sb_if.slave     bus
`ifdef HDU_PERF_CNT_EN
    ,
    output logic [31:0] perf_raw_o,
    output logic [31:0] perf_waw_o,
    output logic [31:0] perf_full_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------------------------------------------------------- state
    logic [DEPTH-1:0] ent_v;
    logic [REG_W-1:0] ent_rd [DEPTH];
    logic [3:0]       hold_cnt;

    // ---------------------------------------------------------- qualifiers
    logic a_rs1_chk, a_rs2_chk, a_rd_chk;
    logic b_rs1_chk, b_rs2_chk, b_rd_chk;

    assign a_rs1_chk = bus.a_valid_i && (bus.a_rs1_i != '0);
    assign a_rs2_chk = bus.a_valid_i && (bus.a_rs2_i != '0);
    assign a_rd_chk  = bus.a_valid_i && bus.a_rd_we_i && (bus.a_rd_i != '0);
    assign b_rs1_chk = bus.b_valid_i && (bus.b_rs1_i != '0);
    assign b_rs2_chk = bus.b_valid_i && (bus.b_rs2_i != '0);
    assign b_rd_chk  = bus.b_valid_i && bus.b_rd_we_i && (bus.b_rd_i != '0);

    // ------------------------------------------ commit decode / live entries
    logic [DEPTH-1:0] commit_hit;
    logic [DEPTH-1:0] live;

    always_comb begin
        commit_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
                if (bus.commit_valid_i[k] &&
                    (bus.commit_id_i[k*ID_W +: ID_W] == ID_W'(i)))
                    commit_hit[i] = 1'b1;
            end
        end
    end

    // A commit arriving this cycle already releases its register for hazard
    // checks, even though the entry is not yet reusable.
    assign live = ent_v & ~commit_hit;

    // ------------------------------------------------------- table hazards
    logic a_raw, a_waw, b_raw_t, b_waw_t;

    always_comb begin
        a_raw   = 1'b0;
        a_waw   = 1'b0;
        b_raw_t = 1'b0;
        b_waw_t = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                if ((a_rs1_chk && (ent_rd[i] == bus.a_rs1_i)) ||
                    (a_rs2_chk && (ent_rd[i] == bus.a_rs2_i)))
                    a_raw = 1'b1;
                if (a_rd_chk && (ent_rd[i] == bus.a_rd_i))
                    a_waw = 1'b1;
                if ((b_rs1_chk && (ent_rd[i] == bus.b_rs1_i)) ||
                    (b_rs2_chk && (ent_rd[i] == bus.b_rs2_i)))
                    b_raw_t = 1'b1;
                if (b_rd_chk && (ent_rd[i] == bus.b_rd_i))
                    b_waw_t = 1'b1;
            end
        end
    end

    // ------------------------------------------------- intra-pair hazards
    logic intra_raw, intra_waw, intra_csr, intra, war;
    logic hz_a, hz_b;

    assign intra_raw = a_rd_chk &&
                       ((b_rs1_chk && (bus.b_rs1_i == bus.a_rd_i)) ||
                        (b_rs2_chk && (bus.b_rs2_i == bus.a_rd_i)));
    assign intra_waw = a_rd_chk && b_rd_chk && (bus.a_rd_i == bus.b_rd_i);
    assign intra_csr = bus.a_csr_i && bus.b_csr_i;
    assign intra     = intra_raw || intra_waw || intra_csr;

    // B would overwrite a source that an older, un-issued A still needs.
    assign war = b_rd_chk &&
                 ((a_rs1_chk && (bus.b_rd_i == bus.a_rs1_i)) ||
                  (a_rs2_chk && (bus.b_rd_i == bus.a_rs2_i)));

    assign hz_a = a_raw || a_waw;
    assign hz_b = b_raw_t || b_waw_t;

    // ------------------------------------------- free count / free indices
    logic [CNT_W-1:0] free_cnt;
    logic [ID_W-1:0]  free_1st, free_2nd;
    logic             found_1st, found_2nd;

    always_comb begin
        free_cnt  = '0;
        free_1st  = '0;
        free_2nd  = '0;
        found_1st = 1'b0;
        found_2nd = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!ent_v[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!found_1st) begin
                    free_1st  = ID_W'(i);
                    found_1st = 1'b1;
                end else if (!found_2nd) begin
                    free_2nd  = ID_W'(i);
                    found_2nd = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------- grants
    logic             g_a, g_b;
    logic [CNT_W-1:0] b_need;
    logic [ID_W-1:0]  b_slot;
    logic             a_full, b_full;

    assign b_need = g_a ? CNT_W'(2) : CNT_W'(1);
    assign a_full = (free_cnt < CNT_W'(1));
    assign b_full = (free_cnt < b_need);

    assign g_a = !bus.flush_i && bus.a_valid_i && !hz_a && !a_full;
    assign g_b = !bus.flush_i && bus.b_valid_i && !hz_b && !intra &&
                 (hold_cnt == 4'd0) && !b_full &&
                 (g_a || !bus.a_valid_i || !war);

    assign b_slot = g_a ? free_2nd : free_1st;

    assign bus.issue_o = {g_b, g_a};
    assign bus.stall_o = bus.flush_i || (bus.a_valid_i && !g_a) ||
                         (bus.b_valid_i && !g_b);
    assign bus.a_id_o  = g_a ? free_1st : '0;
    assign bus.b_id_o  = g_b ? b_slot   : '0;
    assign bus.lock_o  = |ent_v;

    // ------------------------------------------------------- table update
    logic [DEPTH-1:0] ent_v_nxt;

    // Commits are applied first so an allocation to the same index wins.
    always_comb begin
        ent_v_nxt = ent_v & ~commit_hit;
        if (g_a)
            ent_v_nxt[free_1st] = a_rd_chk;
        if (g_b)
            ent_v_nxt[b_slot] = b_rd_chk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_rd[i] <= '0;
        end else begin
            ent_v <= ent_v_nxt;
            if (g_a)
                ent_rd[free_1st] <= bus.a_rd_i;
            if (g_b)
                ent_rd[b_slot] <= bus.b_rd_i;
        end
    end

    // ------------------------------------------------ branch shadow hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (bus.flush_i)
            hold_cnt <= '0;
        else if (g_a && bus.a_br_i)
            hold_cnt <= 4'(BR_HOLD);
        else if (hold_cnt != 4'd0)
            hold_cnt <= hold_cnt - 4'd1;
    end

`ifdef HDU_PERF_CNT_EN
    // --------------------------------------------- performance counters
    logic den_a, den_b, ev_raw, ev_waw, ev_full;

    assign den_a   = bus.a_valid_i && !g_a;
    assign den_b   = bus.b_valid_i && !g_b;
    assign ev_raw  = (den_a && a_raw) || (den_b && (b_raw_t || intra_raw));
    assign ev_waw  = (den_a && a_waw) || (den_b && (b_waw_t || intra_waw));
    assign ev_full = (den_a && a_full) || (den_b && b_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_raw_o  <= '0;
            perf_waw_o  <= '0;
            perf_full_o <= '0;
        end else if (!bus.flush_i) begin
            if (ev_raw)
                perf_raw_o <= perf_raw_o + 32'd1;
            if (ev_waw)
                perf_waw_o <= perf_waw_o + 32'd1;
            if (ev_full)
                perf_full_o <= perf_full_o + 32'd1;
        end
    end
`endif

endmodule
